// File: rtl/resp_chk_pkg.sv
// resp_chk_pkg: shared FSM state type and MISR polynomial/seed defaults
package resp_chk_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_e;
  localparam logic [15:0] DEF_POLY = 16'h1021;
  localparam logic [15:0] DEF_SEED = 16'hFFFF;
endpackage

// File: rtl/misr_step.sv
// misr_step: one combinational MISR update; ports sig/data in, next_sig out
module misr_step #(
  parameter int RESP_W = 3,
  parameter int SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY = 16'h1021
) (
  input  logic [SIG_W-1:0]  sig,
  input  logic [RESP_W-1:0] data,
  output logic [SIG_W-1:0]  next_sig
);
  assign next_sig = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(data);
endmodule

// File: rtl/resp_misr_checker.sv
// resp_misr_checker: compacts num_samples response words into a MISR and compares with golden
// ports: start/abort/num_samples/golden control a run; resp_valid/resp_ready/resp_data carry words;
// signature/sample_count/busy/done/pass report progress and result
module resp_misr_checker
  import resp_chk_pkg::*;
#(
  parameter int RESP_W = 3,
  parameter int SIG_W = 16,
  parameter int CNT_W = 8,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(DEF_POLY),
  parameter logic [SIG_W-1:0] SEED = SIG_W'(DEF_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic [SIG_W-1:0]  golden,
  input  logic              resp_valid,
  input  logic [RESP_W-1:0] resp_data,
  output logic              resp_ready,
  output logic [SIG_W-1:0]  signature,
  output logic [CNT_W-1:0]  sample_count,
  output logic              busy,
  output logic              done,
  output logic              pass
);
  state_e state_q, state_d;
  logic [SIG_W-1:0] signature_q, signature_d, golden_q, golden_d, next_sig;
  logic [CNT_W-1:0] count_q, count_d, num_q, num_d, count_inc;
  logic done_q, done_d, pass_q, pass_d, hs;
  misr_step #(.RESP_W(RESP_W), .SIG_W(SIG_W), .POLY(POLY)) u_step (
    .sig(signature_q), .data(resp_data), .next_sig(next_sig)
  );
  assign resp_ready = state_q == RUN;
  assign busy = (state_q == RUN) || (state_q == CMP);
  assign hs = resp_valid && resp_ready;
  assign count_inc = count_q + 1'b1;
  assign signature = signature_q;
  assign sample_count = count_q;
  assign done = done_q;
  assign pass = pass_q;
  always_comb begin
    state_d = state_q;
    signature_d = signature_q;
    golden_d = golden_q;
    count_d = count_q;
    num_d = num_q;
    done_d = done_q;
    pass_d = pass_q;
    if (abort) begin
      state_d = IDLE;
      done_d = 1'b0;
      pass_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          num_d = num_samples;
          golden_d = golden;
          signature_d = SEED;
          count_d = '0;
          done_d = 1'b0;
          pass_d = 1'b0;
          state_d = (num_samples == '0) ? CMP : RUN;
        end
        RUN: if (hs) begin
          signature_d = next_sig;
          count_d = count_inc;
          state_d = (count_inc == num_q) ? CMP : RUN;
        end
        default: begin
          pass_d = signature_q == golden_q;
          done_d = 1'b1;
          state_d = DONE;
        end
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      signature_q <= SEED;
      golden_q <= '0;
      count_q <= '0;
      num_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      state_q <= state_d;
      signature_q <= signature_d;
      golden_q <= golden_d;
      count_q <= count_d;
      num_q <= num_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end
endmodule

// File: tb/tb_resp_misr_checker.sv
// tb_resp_misr_checker: directed scenarios with hand-computed MISR signatures
module tb_resp_misr_checker;
  logic clk = 1'b0, rst_n, start, abort, resp_valid, resp_ready, busy, done, pass;
  logic [7:0] num_samples, sample_count;
  logic [15:0] golden, signature;
  logic [2:0] resp_data;
  int vectors = 0, miscompares = 0;
  resp_misr_checker dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .num_samples(num_samples),
    .golden(golden), .resp_valid(resp_valid), .resp_data(resp_data), .resp_ready(resp_ready),
    .signature(signature), .sample_count(sample_count), .busy(busy), .done(done), .pass(pass)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst_n = 0; start = 1; abort = 0; num_samples = 8'd3; golden = 16'h1234; resp_valid = 1; resp_data = 3'd7;
    tick();
    tick();
    vectors++;
    if ({busy, resp_ready, done, pass} !== 4'b0000) begin $display("FAIL reset_flags got %b want 0000", {busy, resp_ready, done, pass}); miscompares++; end
    vectors++;
    if (signature !== 16'hFFFF || sample_count !== 8'd0) begin $display("FAIL reset_state sig=%h cnt=%0d want ffff/0", signature, sample_count); miscompares++; end
    rst_n = 1; start = 0; resp_valid = 0;
    tick();
    vectors++;
    if (busy !== 1'b0) begin $display("FAIL reset_idle busy=%b want 0", busy); miscompares++; end
  endtask
  task automatic test_single_pass();
    start = 1; num_samples = 8'd1; golden = 16'hEFDA;
    tick();
    start = 0;
    vectors++;
    if ({busy, resp_ready, done} !== 3'b110) begin $display("FAIL single_run got %b want 110", {busy, resp_ready, done}); miscompares++; end
    resp_valid = 1; resp_data = 3'b101;
    tick();
    resp_valid = 0;
    vectors++;
    if ({busy, resp_ready, done} !== 3'b100 || signature !== 16'hEFDA || sample_count !== 8'd1) begin $display("FAIL single_cmp flags=%b sig=%h cnt=%0d want 100/efda/1", {busy, resp_ready, done}, signature, sample_count); miscompares++; end
    tick();
    vectors++;
    if ({busy, done, pass} !== 3'b011 || signature !== 16'hEFDA) begin $display("FAIL single_done flags=%b sig=%h want 011/efda", {busy, done, pass}, signature); miscompares++; end
    tick();
    vectors++;
    if ({done, pass} !== 2'b11) begin $display("FAIL single_hold got %b want 11", {done, pass}); miscompares++; end
  endtask
  task automatic test_single_fail();
    start = 1; num_samples = 8'd1; golden = 16'h0000;
    tick();
    start = 0; resp_valid = 1; resp_data = 3'b101;
    tick();
    resp_valid = 0;
    tick();
    vectors++;
    if ({done, pass} !== 2'b10 || signature !== 16'hEFDA) begin $display("FAIL fail_done flags=%b sig=%h want 10/efda", {done, pass}, signature); miscompares++; end
    abort = 1;
    tick();
    abort = 0;
    vectors++;
    if ({busy, done, pass} !== 3'b000 || signature !== 16'hEFDA || sample_count !== 8'd1) begin $display("FAIL abort_done flags=%b sig=%h cnt=%0d want 000/efda/1", {busy, done, pass}, signature, sample_count); miscompares++; end
  endtask
  task automatic test_zero(input logic [15:0] g, input logic exp_pass);
    start = 1; num_samples = 8'd0; golden = g; resp_valid = 1; resp_data = 3'd6;
    tick();
    start = 0;
    vectors++;
    if ({busy, resp_ready, done} !== 3'b100) begin $display("FAIL zero_cmp got %b want 100", {busy, resp_ready, done}); miscompares++; end
    tick();
    resp_valid = 0;
    vectors++;
    if ({done, pass} !== {1'b1, exp_pass} || signature !== 16'hFFFF || sample_count !== 8'd0) begin $display("FAIL zero_done flags=%b sig=%h cnt=%0d want %b/ffff/0", {done, pass}, signature, sample_count, {1'b1, exp_pass}); miscompares++; end
  endtask
  task automatic test_toggle();
    start = 1; num_samples = 8'd4; golden = 16'h0E1D;
    tick();
    for (int k = 0; k < 10; k++) begin
      start = (k == 1);
      num_samples = (k == 1) ? 8'd9 : 8'd4;
      golden = (k == 1) ? 16'h0000 : 16'h0E1D;
      resp_valid = (k % 2 == 0);
      resp_data = (k % 2 == 0) ? 3'(k / 2 + 1) : 3'd7;
      tick();
      if (k == 3) begin
        vectors++;
        if (sample_count !== 8'd2 || signature !== 16'hCF9F || busy !== 1'b1) begin $display("FAIL toggle_mid cnt=%0d sig=%h busy=%b want 2/cf9f/1", sample_count, signature, busy); miscompares++; end
      end
    end
    start = 0; resp_valid = 0;
    vectors++;
    if (sample_count !== 8'd4 || signature !== 16'h0E1D) begin $display("FAIL toggle_count cnt=%0d sig=%h want 4/0e1d", sample_count, signature); miscompares++; end
    vectors++;
    if ({busy, resp_ready, done, pass} !== 4'b0011) begin $display("FAIL toggle_done got %b want 0011", {busy, resp_ready, done, pass}); miscompares++; end
  endtask
  task automatic test_abort();
    start = 1; num_samples = 8'd5; golden = 16'h0000;
    tick();
    start = 0;
    for (int k = 1; k <= 2; k++) begin
      resp_valid = 1; resp_data = 3'(k);
      tick();
    end
    resp_data = 3'd3; abort = 1; start = 1;
    tick();
    abort = 0; start = 0; resp_valid = 0;
    vectors++;
    if ({busy, resp_ready, done, pass} !== 4'b0000) begin $display("FAIL abort_flags got %b want 0000", {busy, resp_ready, done, pass}); miscompares++; end
    vectors++;
    if (sample_count !== 8'd2 || signature !== 16'hCF9F) begin $display("FAIL abort_state cnt=%0d sig=%h want 2/cf9f", sample_count, signature); miscompares++; end
  endtask
  task automatic test_reset_mid();
    start = 1; num_samples = 8'd5; golden = 16'h0000;
    tick();
    start = 0;
    for (int k = 1; k <= 2; k++) begin
      resp_valid = 1; resp_data = 3'(k);
      tick();
    end
    vectors++;
    if (signature !== 16'hCF9F || sample_count !== 8'd2) begin $display("FAIL mid_pre sig=%h cnt=%0d want cf9f/2", signature, sample_count); miscompares++; end
    rst_n = 0;
    tick();
    rst_n = 1; resp_valid = 0;
    vectors++;
    if ({busy, resp_ready, done} !== 3'b000 || signature !== 16'hFFFF || sample_count !== 8'd0) begin $display("FAIL mid_reset flags=%b sig=%h cnt=%0d want 000/ffff/0", {busy, resp_ready, done}, signature, sample_count); miscompares++; end
  endtask
  initial begin
    test_reset();
    test_single_pass();
    test_single_fail();
    test_zero(16'hFFFF, 1'b1);
    test_zero(16'h1234, 1'b0);
    test_toggle();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
